// File: rtl/inst_sequencer_if.sv
// inst_sequencer_if: instruction valid/ready handshake between an instruction source and the sequencer
interface inst_sequencer_if #(
    parameter int INST_W = 16
);
    logic [INST_W-1:0] INST;
    logic              inst_valid;
    logic              inst_ready;

    modport master (output INST, inst_valid, input inst_ready);
    modport slave  (input INST, inst_valid, output inst_ready);
endinterface

// File: rtl/inst_sequencer.sv
// inst_sequencer: multi-cycle READ/EXEC/WRITE sequencer driving the register-file/ALU datapath
module inst_sequencer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int INST_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              res,
    inst_sequencer_if.slave   bus,
    output logic [3:0]        OP,
    output logic [REG_AW-1:0] LSEL,
    output logic [REG_AW-1:0] RSEL,
    output logic [REG_AW-1:0] OSEL,
    output logic              LOUT,
    output logic              ROUT,
    output logic              OIN,
    output logic [DATA_W-1:0] Rbus,
    output logic              ill_err,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_MOV   = 4'd4;
    localparam logic [3:0] OP_LOADI = 4'd5;
    localparam logic [3:0] OP_NOP   = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;
    localparam int IMM_W = INST_W - 4 - REG_AW;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              ill_err_q, ill_err_d;
    logic              accept;
    logic [3:0]        in_op;
    logic [3:0]        op;
    logic [REG_AW-1:0] dst, src1, src2;
    logic [IMM_W-1:0]  imm;
    logic              alu_phase, is_mov;

    assign in_op = bus.INST[INST_W-1 -: 4];
    assign op    = inst_q[INST_W-1 -: 4];
    assign dst   = inst_q[INST_W-5 -: REG_AW];
    assign src1  = inst_q[INST_W-5-REG_AW -: REG_AW];
    assign src2  = inst_q[INST_W-5-2*REG_AW -: REG_AW];
    assign imm   = inst_q[INST_W-5-REG_AW:0];

    // ready is forced low while reset is held so nothing is accepted until release
    assign bus.inst_ready = (state_q == S_IDLE) && !res;
    assign accept         = (state_q == S_IDLE) && bus.inst_valid;

    // next state: latch on accept, walk the phases, retire on leaving WRITE or on NOP/HALT
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        retire_cnt_d = retire_cnt_q;
        ill_err_d    = 1'b0;
        if (accept) begin
            inst_d = bus.INST;
            case (in_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: state_d = S_READ;
                OP_LOADI: state_d = S_WRITE;
                OP_NOP:   retire_cnt_d = retire_cnt_q + CNT_W'(1);
                OP_HALT: begin
                    state_d      = S_HALT;
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                end
                default:  ill_err_d = 1'b1;
            endcase
        end else begin
            case (state_q)
                S_READ:  state_d = S_EXEC;
                S_EXEC:  state_d = S_WRITE;
                S_WRITE: begin
                    state_d      = S_IDLE;
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                end
                default: state_d = state_q;
            endcase
        end
    end

    // state, latched instruction, retire counter and error pulse registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= S_IDLE;
            inst_q       <= '0;
            retire_cnt_q <= '0;
            ill_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            retire_cnt_q <= retire_cnt_d;
            ill_err_q    <= ill_err_d;
        end
    end

    // datapath controls decoded from the phase and the latched instruction; LOADI never drives the ALU
    always_comb begin
        is_mov    = (op == OP_MOV);
        alu_phase = (state_q == S_READ) || (state_q == S_EXEC) || (state_q == S_WRITE && op != OP_LOADI);
        OP        = alu_phase ? op : 4'd0;
        LSEL      = alu_phase ? src1 : '0;
        LOUT      = alu_phase;
        ROUT      = alu_phase && !is_mov;
        RSEL      = (alu_phase && !is_mov) ? src2 : '0;
        OIN       = (state_q == S_WRITE);
        OSEL      = (state_q == S_WRITE) ? dst : '0;
        Rbus      = (state_q == S_WRITE && op == OP_LOADI) ? DATA_W'($signed(imm)) : '0;
    end

    assign ill_err    = ill_err_q;
    assign halted     = (state_q == S_HALT);
    assign retire_cnt = retire_cnt_q;
endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Parametrised multi-cycle successor to the single-cycle instruction decoder.
- Accepts one instruction per valid/ready handshake and latches it.
- Sequences the register-file/ALU datapath through READ, EXEC and WRITE phases using LSEL/RSEL/OSEL, LOUT/ROUT/OIN, OP and the immediate bus Rbus.
- Adds HALT, illegal-opcode flagging and a retired-instruction counter.

Parameters:
- DATA_W, 16: datapath width; sets the width of Rbus.
- REG_AW, 3: register select width; the register file holds 2**REG_AW registers.
- INST_W, 16: instruction width; must satisfy INST_W >= 4+3*REG_AW.
- CNT_W, 8: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  reset; asynchronous, active-high.
- INST  in  INST_W  instruction word; sampled only on an accept.
- inst_valid  in  1  INST holds a valid instruction.
- inst_ready  out  1  sequencer can accept an instruction this cycle.
- OP  out  4  ALU operation code.
- LSEL  out  REG_AW  left-operand register select.
- RSEL  out  REG_AW  right-operand register select.
- OSEL  out  REG_AW  destination register select.
- LOUT  out  1  selected left register drives the ALU L input.
- ROUT  out  1  selected right register drives the ALU R input.
- OIN  out  1  destination register loads its input on this rising edge.
- Rbus  out  DATA_W  immediate value, sign-extended.
- ill_err  out  1  one-cycle pulse on an illegal opcode.
- halted  out  1  sequencer is halted.
- retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Instruction fields:
  - op = INST[INST_W-1 -: 4]
  - dst = next REG_AW bits
  - src1 = next REG_AW bits
  - src2 = next REG_AW bits
  - imm = INST[INST_W-5-REG_AW:0]
- Opcodes use the define.v macros: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LOADI, OP_NOP, OP_HALT. Any other value is illegal.
- Accept occurs on a rising edge with inst_valid && inst_ready. INST is latched into an internal register and is not observed again until the next accept.
- inst_ready = 1 only in state IDLE. A source must hold INST and inst_valid until the instruction is accepted.
- States: IDLE, READ, EXEC, WRITE, HALT. Transitions on each rising edge:
  - IDLE: no accept → stay in IDLE.
  - IDLE, accept ADD/SUB/AND/OR/MOV → READ.
  - IDLE, accept LOADI → WRITE.
  - IDLE, accept NOP → stay in IDLE; retire.
  - IDLE, accept HALT → HALT; retire.
  - IDLE, accept illegal opcode → stay in IDLE; ill_err=1 next cycle; no retire.
  - READ → EXEC.
  - EXEC → WRITE.
  - WRITE → IDLE; retire.
  - HALT → stays in HALT until res.
- Outputs are decoded from the state and the latched instruction. Every output is 0 unless listed below.
- READ and EXEC:
  - OP = latched op
  - LSEL = src1, LOUT = 1
  - RSEL = src2, ROUT = 1 for every ALU op except MOV
  - MOV: ROUT = 0, RSEL = 0
- WRITE (ALU ops):
  - OP, LSEL, RSEL, LOUT and ROUT keep their EXEC values.
  - OSEL = dst, OIN = 1.
- WRITE (LOADI):
  - OSEL = dst, OIN = 1.
  - Rbus = imm sign-extended to DATA_W; truncated if DATA_W is less than the imm width.
  - OP, LOUT and ROUT stay 0.
- halted = 1 in state HALT.
- Latency, counted from the accept edge:
  - ALU op: 3 cycles; inst_ready is 1 again on the 4th cycle.
  - LOADI: 1 cycle.
  - NOP, HALT, illegal: 0 cycles.
- retire_cnt increments by 1 at each retire and wraps modulo 2**CNT_W.
- ill_err is registered: high for exactly the cycle after the accept edge.
- inst_valid while inst_ready=0 is ignored and has no side effects.
- Asynchronous reset:
  - Reset values: state = IDLE; latched instruction = 0; retire_cnt = 0; ill_err = 0.
  - Every output = 0 immediately, except inst_ready, which becomes 1 when res deasserts.
  - Reset during READ/EXEC/WRITE aborts the instruction: OIN falls immediately, no write occurs, no retire is counted.

Test Plan:
- Reset then LOADI dst=1 imm=0x006, inst_valid for 1 cycle:
  - next cycle: OIN=1, OSEL=001, Rbus=0x0006;
  - following cycle: inst_ready=1, retire_cnt=1.
- LOADI dst=2 imm=0x1FF (9-bit -1) → during WRITE Rbus=0xFFFF.
- ADD dst=3 src1=1 src2=2 accepted:
  - READ: LOUT=ROUT=1, LSEL=001, RSEL=010, OP=OP_ADD;
  - EXEC: same values;
  - WRITE: OIN=1, OSEL=011;
  - inst_ready=0 for 3 cycles and returns to 1 on the 4th.
- SUB held valid while busy, followed by a second SUB → each accepted only when inst_ready=1; retire_cnt increases by exactly 2 and no instruction is lost.
- Illegal opcode then NOP:
  - illegal: ill_err pulses for 1 cycle, retire_cnt unchanged, inst_ready stays 1;
  - NOP: retire_cnt +1, all control outputs 0.
- Other boundary cases:
  - HALT: halted=1 and inst_ready=0, persisting across 10 valid requests.
  - res pulsed during the EXEC of an ADD: outputs 0 at once, no OIN pulse, retire_cnt=0.
  - 256 NOPs with CNT_W=8: retire_cnt wraps to 0.
